alu_operand_loader: RTL and testbench

Upstream feeder for the 4-bit pre-ALU (sum/AND) stage. It collects operand A, operand B and an opcode as three serial beats on a nibble bus using a valid/ready handshake. It then drives A/B/sel to the pre-ALU, captures the ALU result C one cycle later, and presents that result downstream with a valid/ready handshake. It also counts completed transactions and flags malformed opcodes.

---
 rtl/alu_operand_loader.sv | 123 ++++++++++++
 tb/tb_alu_operand_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// Serial operand/opcode loader that feeds a 4-bit pre-ALU and captures its result.
// Three beats (A, B, opcode) come in on a nibble bus, and the result leaves through a single-entry valid/ready buffer.
`timescale 1ns/1ps

module alu_operand_loader #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             sel,
    input  logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             op_err,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sel;
    logic [WIDTH-1:0] r_res;
    logic             r_res_valid;
    logic             r_op_err;
    logic [CNT_W-1:0] r_txn_count;

    logic w_load_state;
    logic w_accept;
    logic w_res_hs;
    logic w_op_bad;

    // din_ready is gated by rst_n so that it reads 0 for the whole reset window.
    assign w_load_state = (r_state == S_A) || (r_state == S_B) || (r_state == S_OP);
    assign din_ready    = rst_n && w_load_state;
    assign w_accept     = din_valid && din_ready;
    assign w_res_hs     = (r_state == S_DONE) && res_ready;
    assign w_op_bad     = |din[WIDTH-1:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_A:     if (w_accept) w_next_state = S_B;
            S_B:     if (w_accept) w_next_state = S_OP;
            S_OP:    if (w_accept) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_DONE;
            S_DONE:  if (res_ready) w_next_state = S_A;
            default: w_next_state = S_A;
        endcase
    end

    // Operand registers keep their values until the next transaction overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= 1'b0;
            r_op_err <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                S_A: r_a <= din;
                S_B: r_b <= din;
                S_OP: begin
                    r_sel <= din[0];
                    if (w_op_bad) begin
                        r_op_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // C is sampled one cycle after the opcode lands, giving the pre-ALU a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_txn_count <= '0;
        end else begin
            if (r_state == S_EXEC) begin
                r_res       <= C;
                r_res_valid <= 1'b1;
            end else if (w_res_hs) begin
                r_res_valid <= 1'b0;
                r_txn_count <= r_txn_count + CNT_W'(1);
            end
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign sel       = r_sel;
    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign op_err    = r_op_err;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader.
// The pre-ALU is modelled behaviourally, and every result is compared with a hand-computed constant.
`timescale 1ns/1ps

module tb_alu_operand_loader;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       sel;
    logic [3:0] C;
    logic [3:0] res;
    logic       res_valid;
    logic       res_ready;
    logic       op_err;
    logic [7:0] txn_count;

    int totalCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    alu_operand_loader #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .C         (C),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .op_err    (op_err),
        .txn_count (txn_count)
    );

    // The pre-ALU model is part of the environment.
    assign C = sel ? (A & B) : (A + B);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one beat and hold it until it is accepted, with a bounded wait.
    task automatic applyStimulus(input logic [3:0] value);
        bit accepted;
        accepted  = 1'b0;
        din       = value;
        din_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (din_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        if (!accepted) checkOutput("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic expectResult(input string tag, input logic [3:0] expRes);
        checkOutput({tag, "_exec_valid"}, {31'd0, res_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        checkOutput({tag, "_res"}, {28'd0, res}, {28'd0, expRes});
    endtask

    task automatic handshake(input string tag, input logic [7:0] expCount);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
        checkOutput({tag, "_count"}, {24'd0, txn_count}, {24'd0, expCount});
    endtask

    task automatic loadAndExec(input string tag, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] op, input logic [3:0] expRes);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(op);
        checkOutput({tag, "_A"}, {28'd0, A}, {28'd0, a});
        checkOutput({tag, "_B"}, {28'd0, B}, {28'd0, b});
        checkOutput({tag, "_sel"}, {31'd0, sel}, {31'd0, op[0]});
        expectResult(tag, expRes);
    endtask

    initial begin
        din       = 4'd0;
        din_valid = 1'b0;
        res_ready = 1'b0;
        rst_n     = 1'b1;
        #3 rst_n  = 1'b0;
        #1;
        checkOutput("rst_din_ready", {31'd0, din_ready}, 32'd0);
        checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_A", {28'd0, A}, 32'd0);
        checkOutput("rst_count", {24'd0, txn_count}, 32'd0);
        checkOutput("rst_op_err", {31'd0, op_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_din_ready", {31'd0, din_ready}, 32'd1);

        // Basic sum: 1 + 1 = 2.
        loadAndExec("t1", 4'h1, 4'h1, 4'h0, 4'h2);
        handshake("t1", 8'd1);

        // 7 + 3 = A, then 7 & 3 = 3.
        loadAndExec("t2", 4'h7, 4'h3, 4'h0, 4'hA);
        handshake("t2", 8'd2);
        loadAndExec("t3", 4'h7, 4'h3, 4'h1, 4'h3);
        handshake("t3", 8'd3);
        checkOutput("hold_B_in_S_A", {28'd0, B}, 32'h3);
        checkOutput("hold_sel_in_S_A", {31'd0, sel}, 32'd1);

        // Wrap: D + 6 = 0x13, which truncates to 3. Then F & B = B.
        loadAndExec("wrap", 4'hD, 4'h6, 4'h0, 4'h3);
        handshake("wrap", 8'd4);
        loadAndExec("and", 4'hF, 4'hB, 4'h1, 4'hB);
        handshake("and", 8'd5);
        checkOutput("op_err_clean", {31'd0, op_err}, 32'd0);

        // A gap in din_valid while in S_B must stall without changing anything.
        applyStimulus(4'h9);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("gap_din_ready", {31'd0, din_ready}, 32'd1);
        checkOutput("gap_A", {28'd0, A}, 32'h9);
        checkOutput("gap_B_old", {28'd0, B}, 32'hB);
        applyStimulus(4'h4);
        applyStimulus(4'h0);
        expectResult("gap", 4'hD);
        handshake("gap", 8'd6);

        // Backpressure: 2 + 3 = 5. The result is held and the next beat waits for the handshake.
        loadAndExec("bp", 4'h2, 4'h3, 4'h0, 4'h5);
        din       = 4'hC;
        din_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_din_ready", {31'd0, din_ready}, 32'd0);
            checkOutput("bp_res", {28'd0, res}, 32'h5);
            checkOutput("bp_A", {28'd0, A}, 32'h2);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checkOutput("bp_count", {24'd0, txn_count}, 32'd7);
        checkOutput("bp_A_before_accept", {28'd0, A}, 32'h2);
        checkOutput("bp_ready_again", {31'd0, din_ready}, 32'd1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        checkOutput("bp_A_accepted", {28'd0, A}, 32'hC);

        // Malformed opcode 0101: sel=1 and op_err set. The result is C & 6 = 4.
        applyStimulus(4'h6);
        applyStimulus(4'h5);
        checkOutput("bad_op_sel", {31'd0, sel}, 32'd1);
        checkOutput("bad_op_err", {31'd0, op_err}, 32'd1);
        expectResult("bad_op", 4'h4);
        handshake("bad_op", 8'd8);

        // op_err is sticky across a good transaction: 3 + 4 = 7.
        loadAndExec("sticky", 4'h3, 4'h4, 4'h0, 4'h7);
        handshake("sticky", 8'd9);
        checkOutput("sticky_op_err", {31'd0, op_err}, 32'd1);

        // Reset asserted mid-cycle after the A and B beats.
        applyStimulus(4'h5);
        applyStimulus(4'h6);
        @(negedge clk);
        rst_n     = 1'b0;
        din       = 4'h9;
        din_valid = 1'b1;
        #1;
        checkOutput("mid_rst_A", {28'd0, A}, 32'd0);
        checkOutput("mid_rst_B", {28'd0, B}, 32'd0);
        checkOutput("mid_rst_sel", {31'd0, sel}, 32'd0);
        checkOutput("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("mid_rst_din_ready", {31'd0, din_ready}, 32'd0);
        checkOutput("mid_rst_op_err", {31'd0, op_err}, 32'd0);
        @(negedge clk);
        checkOutput("mid_rst_hold_ready", {31'd0, din_ready}, 32'd0);
        checkOutput("mid_rst_hold_A", {28'd0, A}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;

        // A fresh transaction after reset: 8 + 8 wraps to 0.
        loadAndExec("post_rst", 4'h8, 4'h8, 4'h0, 4'h0);
        handshake("post_rst", 8'd1);
        checkOutput("post_rst_op_err", {31'd0, op_err}, 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
